vector_operand_loader: RTL
==========================

VECTOR_OPERAND_LOADER -- requirements
Module: vector_operand_loader

Interface
REQ-001 SHALL have parameter VECTOR_SIZE, default 4: number of elements per vector.
REQ-002 SHALL have parameter DATA_WIDTH, default 31: element and result width in bits.
REQ-003 SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: element pair on in_a/in_b is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: loader accepts an element pair this cycle.
REQ-007 SHALL have port in_a, input, DATA_WIDTH: next element of vec1.
REQ-008 SHALL have port in_b, input, DATA_WIDTH: next element of vec2.
REQ-009 SHALL have port in_last, input, 1 bit: current beat is the final element pair.
REQ-010 SHALL have port vec1, output, VECTOR_SIZE x DATA_WIDTH array: assembled operand 1 to the dot-product stage.
REQ-011 SHALL have port vec2, output, VECTOR_SIZE x DATA_WIDTH array: assembled operand 2.
REQ-012 SHALL have port vec_valid, output, 1 bit: vec1/vec2 complete and held stable.
REQ-013 SHALL have port dp_valid, input, 1 bit: dot-product stage reports its result ready.
REQ-014 SHALL have port dp_result, input, DATA_WIDTH: dot-product result.
REQ-015 SHALL have port result, output, DATA_WIDTH: captured dot-product result.
REQ-016 SHALL have port res_valid, output, 1 bit: result valid.
REQ-017 SHALL have port res_ready, input, 1 bit: consumer accepts result.

Function
REQ-018 SHALL implement FSM with states LOAD, ISSUE and RESULT.
REQ-019 SHALL drive in_ready=1 only in LOAD, vec_valid=1 only in ISSUE, and res_valid=1 only in RESULT.
REQ-020 SHALL, in LOAD, on in_valid&&in_ready, write in_a/in_b to vec1[idx]/vec2[idx] and increment idx (width clog2(VECTOR_SIZE)+1).
REQ-021 SHALL go LOAD->ISSUE on the accepted beat where in_last=1 or idx==VECTOR_SIZE-1; vec_valid rises the following cycle.
REQ-022 SHALL leave elements beyond the last accepted beat at zero (early in_last gives zero-fill).
REQ-023 SHALL hold vec1/vec2 constant from the ISSUE entry until the next LOAD entry.
REQ-024 SHALL, in ISSUE, on dp_valid=1, register dp_result into result and go to RESULT next cycle.
REQ-025 SHALL, in RESULT, hold result until res_valid&&res_ready, then go to LOAD, clear idx, and zero vec1/vec2 in the same edge.
REQ-026 SHALL ignore dp_valid outside ISSUE and ignore in_valid outside LOAD (no write, no idx change).
REQ-027 SHALL pass dp_result through unmodified; no truncation or saturation.
REQ-028 SHALL support back-to-back vectors with a minimum of 1 idle cycle (the RESULT->LOAD edge) between vectors.

Reset
REQ-029 SHALL, while reset=0, asynchronously force state=LOAD, idx=0, vec1/vec2=0, result=0, in_ready=1, vec_valid=0, res_valid=0.
REQ-030 SHALL treat reset mid-operation (any state) as discarding the partial vector and any pending result.

Structure
REQ-031 SHALL place DATA_WIDTH/VECTOR_SIZE defaults and the state enum (LOAD, ISSUE, RESULT) in shared package vdp_pkg.
REQ-032 SHALL be a single module with no sub-modules; the dot-product stage is instantiated alongside it by the parent.

Verification
REQ-033 SHALL test: beats (1,5),(2,6),(3,7),(4,8) -> vec1={1,2,3,4}, vec2={5,6,7,8}, vec_valid=1; then dp_valid with dp_result=70 -> result=70, res_valid=1.
REQ-034 SHALL test: beats (9,2),(3,3) with in_last on beat 2 -> vec1={9,3,0,0}, vec2={2,3,0,0}, vec_valid=1.
REQ-035 SHALL test: res_ready held 0 for 5 cycles in RESULT -> result=70 is stable and res_valid=1 throughout; in_ready=0 throughout.
REQ-036 SHALL test: dp_valid pulsed during LOAD, and in_valid driven during ISSUE -> no state, idx or vector change.
REQ-037 SHALL test: reset=0 asserted after 2 beats -> all outputs at reset values immediately; the next 4 beats load a fresh, correct vector.
REQ-038 SHALL test: two vectors streamed back-to-back with res_ready=1 -> both results delivered in order, with exactly one idle in_ready-high gap.

Source files
------------

// File: rtl/vdp_pkg.sv
// Shared definitions for the vector dot-product path.
//   VDP_DATA_WIDTH  : default element / result width in bits
//   VDP_VECTOR_SIZE : default number of elements per vector
//   vdp_state_e     : loader sequencing states (LOAD, ISSUE, RESULT)
package vdp_pkg;

    localparam int VDP_DATA_WIDTH  = 31;
    localparam int VDP_VECTOR_SIZE = 4;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        ISSUE  = 2'd1,
        RESULT = 2'd2
    } vdp_state_e;

endpackage : vdp_pkg

// File: rtl/vector_operand_loader.sv
// Collects element pairs into two operand vectors, presents them to the
// dot-product stage, captures its result, and hands the result downstream.
//
// Ports:
//   clk        : clock, all state on rising edge
//   reset      : asynchronous active-low reset
//   in_valid   : element pair on in_a/in_b is valid
//   in_ready   : loader accepts an element pair (LOAD only)
//   in_a/in_b  : next element of vec1/vec2
//   in_last    : current beat is the final element pair
//   vec1/vec2  : assembled operands, stable while vec_valid
//   vec_valid  : operands complete (ISSUE only)
//   dp_valid   : dot-product result ready (honoured in ISSUE only)
//   dp_result  : dot-product result, captured unmodified
//   result     : captured result
//   res_valid  : result valid (RESULT only)
//   res_ready  : consumer accepts result
module vector_operand_loader
    import vdp_pkg::*;
#(
    parameter int VECTOR_SIZE = VDP_VECTOR_SIZE,
    parameter int DATA_WIDTH  = VDP_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    input  logic                  in_last,
    output logic [DATA_WIDTH-1:0] vec1 [VECTOR_SIZE],
    output logic [DATA_WIDTH-1:0] vec2 [VECTOR_SIZE],
    output logic                  vec_valid,
    input  logic                  dp_valid,
    input  logic [DATA_WIDTH-1:0] dp_result,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  res_valid,
    input  logic                  res_ready
);

    localparam int AW = $clog2(VECTOR_SIZE);
    localparam int IW = AW + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(VECTOR_SIZE - 1);

    vdp_state_e    state;
    logic [IW-1:0] idx;

    // Handshake outputs are registered alongside the state so each is a
    // pure function of the current state without any decode logic.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= LOAD;
            idx       <= '0;
            result    <= '0;
            in_ready  <= 1'b1;
            vec_valid <= 1'b0;
            res_valid <= 1'b0;
            for (int i = 0; i < VECTOR_SIZE; i++) begin
                vec1[i] <= '0;
                vec2[i] <= '0;
            end
        end else begin
            case (state)
                LOAD: begin
                    if (in_valid && in_ready) begin
                        vec1[idx[AW-1:0]] <= in_a;
                        vec2[idx[AW-1:0]] <= in_b;
                        idx <= idx + IW'(1);
                        // Early in_last leaves the untouched tail at zero.
                        if (in_last || idx == LAST_IDX) begin
                            state     <= ISSUE;
                            in_ready  <= 1'b0;
                            vec_valid <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (dp_valid) begin
                        result    <= dp_result;
                        state     <= RESULT;
                        vec_valid <= 1'b0;
                        res_valid <= 1'b1;
                    end
                end
                RESULT: begin
                    // Vectors are zeroed here so the next load starts clean.
                    if (res_valid && res_ready) begin
                        state     <= LOAD;
                        idx       <= '0;
                        res_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        for (int i = 0; i < VECTOR_SIZE; i++) begin
                            vec1[i] <= '0;
                            vec2[i] <= '0;
                        end
                    end
                end
                default: begin
                    state     <= LOAD;
                    idx       <= '0;
                    in_ready  <= 1'b1;
                    vec_valid <= 1'b0;
                    res_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule : vector_operand_loader
